fir_frame_ctrl: RTL and testbench
=================================

FIR_FRAME_CTRL -- requirements
Module: fir_frame_ctrl

Interface
REQ-001 Parameters, one per line:
- TAPS, 33, filter tap count; flush length is TAPS-1.
- XW, 15, sample width.
- YW, 19, filter output width.
- LW, 10, frame-length width.
REQ-002 Ports, one per line:
- Clk, in, 1, single clock; all state on rising edge.
- Reset_n, in, 1, asynchronous active-low reset.
- Start, in, 1, frame start request.
- Frame_Len, in, LW, number of samples in frame; sampled on accepted Start.
- In_Valid, in, 1, input sample valid.
- In_Data, in, XW, signed input sample.
- In_Ready, out, 1, controller accepts In_Data.
- Fir_X, out, XW, sample driven to filter datapath.
- Fir_En, out, 1, filter advance enable; filter updates its registers only when high.
- Fir_Y, in, YW, registered filter output, valid the cycle after Fir_En.
- Out_Valid, out, 1, Out_Data holds a filter result.
- Out_Data, out, YW, equals Fir_Y.
- Out_Ready, in, 1, downstream accepts Out_Data.
- Out_Last, out, 1, marks final output of frame.
- Busy, out, 1, high in any state other than IDLE.
- Done, out, 1, one-cycle end-of-frame pulse.

Function
REQ-003 The controller SHALL implement states IDLE, RUN, FLUSH and DRAIN.
REQ-004 In IDLE, Start=1 SHALL latch Frame_Len and move to RUN, or to DRAIN if Frame_Len=0.
REQ-005 Start SHALL be ignored in all states other than IDLE.
REQ-006 Slot free SHALL be defined as Out_Valid=0 or Out_Ready=1.
REQ-007 In RUN, In_Ready SHALL equal slot free; in every other state In_Ready SHALL be 0.
REQ-008 In RUN, In_Valid and In_Ready both high SHALL set Fir_En=1 with Fir_X=In_Data combinationally, and increment the sample counter.
REQ-009 After the Frame_Len-th accepted sample, the state SHALL become FLUSH on the next edge.
REQ-010 In FLUSH, each cycle with slot free SHALL assert Fir_En=1 with Fir_X=0 and increment a flush counter.
REQ-011 After TAPS-1 flush enables, the state SHALL become DRAIN, leaving all filter delay registers zero for the next frame.
REQ-012 Fir_En SHALL never be high while slot free is 0, so Fir_Y, and therefore Out_Data, stays stable under backpressure.
REQ-013 Out_Valid SHALL set on the edge after any Fir_En=1 cycle and clear on an Out_Ready handshake without a concurrent Fir_En; a simultaneous handshake and Fir_En SHALL keep it set, giving one-cycle latency.
REQ-014 When Fir_En=0, Fir_X SHALL be 0.
REQ-015 Each frame SHALL produce exactly Frame_Len+TAPS-1 outputs, or none if Frame_Len=0.
REQ-016 Out_Last SHALL be high with the final Out_Valid of a frame.
REQ-017 DRAIN SHALL wait for Out_Valid=0 or the final handshake, then pulse Done for one cycle and return to IDLE in that same cycle, with Busy=0.
REQ-018 Counters SHALL be LW bits (samples) and clog2(TAPS) bits (flush), with no wrap within a frame.
REQ-019 Frame_Len changes after the latching Start SHALL have no effect.

Reset
REQ-020 Reset_n=0 SHALL asynchronously force IDLE, zero all counters, and drive In_Ready, Fir_En, Fir_X, Out_Valid, Out_Last, Busy and Done to 0.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no Done pulse; the filter datapath shares Reset_n, so its state clears too.
REQ-022 The first Start after Reset_n deasserts SHALL be honoured.

Verification
REQ-023 Impulse test: Frame_Len=1, In_Data=8192, Out_Ready=1 -> 33 outputs matching the golden filter model, Out_Last on the 33rd, then Done.
REQ-024 Full-rate test: Start at cycle 0, Frame_Len=4, In_Valid=1, Out_Ready=1 ->
- samples accepted cycles 1-4;
- Fir_En high cycles 1-36;
- Out_Valid high cycles 2-37;
- Done pulse in cycle 38.
REQ-025 Backpressure test: Out_Ready=0 for 5 cycles mid-RUN -> Fir_En=0, In_Ready=0, Out_Data constant throughout, no sample lost.
REQ-026 Zero-length test: Frame_Len=0 -> Done pulse one cycle after DRAIN entry, Out_Valid never asserted.
REQ-027 Reset test: Reset_n low after 3 samples accepted -> all outputs 0 immediately, IDLE; the next frame's outputs match the model from zero state.
REQ-028 Ignored-Start test: Start pulsed during RUN with a different Frame_Len -> ignored; the output count equals the originally latched Frame_Len+32.

Source files
------------

// File: rtl/fir_frame_ctrl.sv
// Frame controller for a streaming FIR datapath. It accepts Frame_Len samples and
// then pushes TAPS-1 zeros through the filter, so the delay line is clean for the
// next frame. It forwards the registered filter output with a one-entry
// valid/ready slot, flags the last output of the frame and pulses Done at the end.
module fir_frame_ctrl #(
  parameter int unsigned TAPS = 33,
  parameter int unsigned XW   = 15,
  parameter int unsigned YW   = 19,
  parameter int unsigned LW   = 10
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [LW-1:0] Frame_Len,
  input  logic          In_Valid,
  input  logic [XW-1:0] In_Data,
  output logic          In_Ready,
  output logic [XW-1:0] Fir_X,
  output logic          Fir_En,
  input  logic [YW-1:0] Fir_Y,
  output logic          Out_Valid,
  output logic [YW-1:0] Out_Data,
  input  logic          Out_Ready,
  output logic          Out_Last,
  output logic          Busy,
  output logic          Done
);

  // Flush counter width; kept at least one bit so degenerate tap counts still elaborate.
  localparam int unsigned FW       = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam bit          HasFlush = (TAPS > 1);
  // Value of the flush counter during the final flush enable.
  localparam logic [FW-1:0] FlushLast = HasFlush ? FW'(TAPS - 2) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDrain
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] samp_cnt_q, samp_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic slot_free;
  logic last_en;  // the current filter enable produces the final output of the frame

  // The output slot can take a new filter result when empty or being emptied.
  assign slot_free = ~out_valid_q | Out_Ready;

  // Next-state, counters and datapath controls.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    samp_cnt_d  = samp_cnt_q;
    flush_cnt_d = flush_cnt_q;
    In_Ready    = 1'b0;
    Fir_En      = 1'b0;
    Fir_X       = '0;
    Done        = 1'b0;
    last_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          len_d       = Frame_Len;
          samp_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = (Frame_Len == '0) ? StDrain : StRun;
        end
      end

      StRun: begin
        In_Ready = slot_free;
        if (In_Valid && slot_free) begin
          Fir_En     = 1'b1;
          Fir_X      = In_Data;
          // Counter reaches len_q at most, which always fits in LW bits.
          samp_cnt_d = samp_cnt_q + LW'(1);
          if (samp_cnt_q == len_q - LW'(1)) begin
            if (HasFlush) begin
              state_d = StFlush;
            end else begin
              state_d = StDrain;
              last_en = 1'b1;
            end
          end
        end
      end

      StFlush: begin
        // Zeros are pushed only when the result slot can absorb the new output,
        // so Fir_Y never moves under a stalled Out_Data.
        if (slot_free) begin
          Fir_En      = 1'b1;
          flush_cnt_d = flush_cnt_q + FW'(1);
          if (flush_cnt_q == FlushLast) begin
            state_d = StDrain;
            last_en = 1'b1;
          end
        end
      end

      StDrain: begin
        // Finish only once the final result has left the slot.
        if (!out_valid_q) begin
          Done    = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Output slot: a filter enable always refills it, a handshake alone empties it.
  always_comb begin
    out_valid_d = Fir_En | (out_valid_q & ~Out_Ready);
    if (Fir_En) begin
      out_last_d = last_en;
    end else if (Out_Ready) begin
      out_last_d = 1'b0;
    end else begin
      out_last_d = out_last_q;
    end
  end

  // State and counter registers; reset abandons any frame in progress.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      samp_cnt_q  <= '0;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      samp_cnt_q  <= samp_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign Out_Valid = out_valid_q;
  assign Out_Last  = out_last_q;
  assign Out_Data  = Fir_Y;
  assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Bench for fir_frame_ctrl: a behavioural FIR stands in for the datapath and
// directed frames are compared against a convolution model and hand-derived timing.
module tb_fir_frame_ctrl;

  localparam int TAPS = 33;
  localparam int XW   = 15;
  localparam int YW   = 19;
  localparam int LW   = 10;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Start;
  logic [LW-1:0] Frame_Len;
  logic          In_Valid;
  logic [XW-1:0] In_Data;
  logic          In_Ready;
  logic [XW-1:0] Fir_X;
  logic          Fir_En;
  logic [YW-1:0] Fir_Y;
  logic          Out_Valid;
  logic [YW-1:0] Out_Data;
  logic          Out_Ready;
  logic          Out_Last;
  logic          Busy;
  logic          Done;

  always #5 Clk = ~Clk;

  fir_frame_ctrl #(
    .TAPS(TAPS),
    .XW  (XW),
    .YW  (YW),
    .LW  (LW)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Frame_Len(Frame_Len),
    .In_Valid (In_Valid),
    .In_Data  (In_Data),
    .In_Ready (In_Ready),
    .Fir_X    (Fir_X),
    .Fir_En   (Fir_En),
    .Fir_Y    (Fir_Y),
    .Out_Valid(Out_Valid),
    .Out_Data (Out_Data),
    .Out_Ready(Out_Ready),
    .Out_Last (Out_Last),
    .Busy     (Busy),
    .Done     (Done)
  );

  // Coefficients in -5..5 keep every test inside the YW range.
  function automatic int coef(input int k);
    return ((k * 5) % 11) - 5;
  endfunction

  // Behavioural filter datapath: registered output, advances only on Fir_En.
  logic signed [XW-1:0] dl [TAPS-1];
  logic        [YW-1:0] fir_y;

  function automatic int fir_sum();
    int acc;
    acc = coef(0) * int'($signed(Fir_X));
    for (int k = 1; k < TAPS; k++) acc += coef(k) * int'(dl[k-1]);
    return acc;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fir_y <= '0;
      for (int k = 0; k < TAPS - 1; k++) dl[k] <= '0;
    end else if (Fir_En) begin
      fir_y <= YW'(fir_sum());
      dl[0] <= $signed(Fir_X);
      for (int k = 1; k < TAPS - 1; k++) dl[k] <= dl[k-1];
    end
  end
  assign Fir_Y = fir_y;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus knobs.
  int xs[$];
  int bp_start, bp_len, s2_cyc, s2_len, rst_after;

  // Per-frame observations.
  int outs[$];
  int lasts[$];
  int acc_first, acc_last, acc_cnt;
  int fen_first, fen_last, fen_cnt;
  int ov_first, ov_last, ov_cnt;
  int done_cyc, done_cnt, busy_after;
  int viol, fx_viol, fen_bp, inr_bp, od_chg;
  logic [YW-1:0] od_ref;
  logic [6:0]    rst_snap;

  // Expected output n: convolution of the frame (plus zero flush) from zero state.
  function automatic int model_y(input int n);
    int acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      if (n - k >= 0 && n - k < xs.size()) acc += coef(k) * xs[n-k];
    end
    return (acc <<< (32 - YW)) >>> (32 - YW);
  endfunction

  task automatic check_data(input string tag);
    for (int i = 0; i < outs.size(); i++) check($sformatf("%s_y%0d", tag, i), outs[i], model_y(i));
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Runs one frame; entered 1 time unit after a rising edge, cycle 0 carries Start.
  task automatic run_frame(input int len, input int max_cyc);
    int  cyc, idx;
    logic in_bp;
    outs.delete();
    lasts.delete();
    acc_first = -1; acc_last = -1; acc_cnt = 0;
    fen_first = -1; fen_last = -1; fen_cnt = 0;
    ov_first  = -1; ov_last  = -1; ov_cnt  = 0;
    done_cyc  = -1; done_cnt = 0;  busy_after = -1;
    viol = 0; fx_viol = 0; fen_bp = 0; inr_bp = 0; od_chg = 0;
    od_ref = '0; rst_snap = '1;
    cyc = 0;
    idx = 0;
    while (1) begin
      if (rst_after >= 0 && idx == rst_after) begin
        Reset_n = 1'b0;
        #1;
        rst_snap = {In_Ready, Fir_En, (Fir_X != '0), Out_Valid, Out_Last, Busy, Done};
        break;
      end
      Start = (cyc == 0) || (cyc == s2_cyc);
      if (cyc == 0) Frame_Len = LW'(len);
      else if (cyc == s2_cyc) Frame_Len = LW'(s2_len);
      In_Valid  = (idx < xs.size());
      In_Data   = In_Valid ? XW'(xs[idx]) : '0;
      in_bp     = (bp_start >= 0) && (cyc >= bp_start) && (cyc < bp_start + bp_len);
      Out_Ready = !in_bp;
      #1;
      if (In_Valid && In_Ready) begin
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
        acc_cnt++;
        idx++;
      end
      if (Fir_En) begin
        if (fen_first < 0) fen_first = cyc;
        fen_last = cyc;
        fen_cnt++;
      end
      if (Out_Valid) begin
        if (ov_first < 0) ov_first = cyc;
        ov_last = cyc;
        ov_cnt++;
      end
      if (Out_Valid && Out_Ready) begin
        outs.push_back(int'($signed(Out_Data)));
        if (Out_Last) lasts.push_back(outs.size() - 1);
      end
      if (Done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (Fir_En && Out_Valid && !Out_Ready) viol++;
      if (!Fir_En && Fir_X != '0) fx_viol++;
      if (in_bp) begin
        if (Fir_En) fen_bp++;
        if (In_Ready) inr_bp++;
        if (cyc == bp_start) od_ref = Out_Data;
        else if (Out_Data != od_ref) od_chg++;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = int'(Busy);
        break;
      end
      if (cyc >= max_cyc) begin
        check("frame_timeout_done_seen", int'(done_cyc >= 0), 1);
        break;
      end
      next_cycle();
      cyc++;
    end
    Start     = 1'b0;
    In_Valid  = 1'b0;
    In_Data   = '0;
    Out_Ready = 1'b1;
  endtask

  task automatic clear_knobs();
    bp_start  = -1;
    bp_len    = 0;
    s2_cyc    = -1;
    s2_len    = 0;
    rst_after = -1;
  endtask

  initial begin
    Reset_n   = 1'b0;
    Start     = 1'b0;
    Frame_Len = '0;
    In_Valid  = 1'b0;
    In_Data   = '0;
    Out_Ready = 1'b1;
    clear_knobs();

    // Reset state.
    repeat (2) @(posedge Clk);
    #1;
    check("rst_in_ready", int'(In_Ready), 0);
    check("rst_fir_en", int'(Fir_En), 0);
    check("rst_fir_x", int'(Fir_X), 0);
    check("rst_out_valid", int'(Out_Valid), 0);
    check("rst_out_last", int'(Out_Last), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    Reset_n = 1'b1;
    next_cycle();

    // Impulse response.
    xs = '{8192};
    run_frame(1, 200);
    check("imp_count", outs.size(), 33);
    check_data("imp");
    check("imp_last_cnt", lasts.size(), 1);
    if (lasts.size() > 0) check("imp_last_idx", lasts[0], 32);
    check("imp_done_cnt", done_cnt, 1);
    next_cycle();

    // Full-rate timing.
    xs = '{100, -50, 25, 7};
    run_frame(4, 200);
    check("fr_acc_first", acc_first, 1);
    check("fr_acc_last", acc_last, 4);
    check("fr_acc_cnt", acc_cnt, 4);
    check("fr_fen_first", fen_first, 1);
    check("fr_fen_last", fen_last, 36);
    check("fr_fen_cnt", fen_cnt, 36);
    check("fr_ov_first", ov_first, 2);
    check("fr_ov_last", ov_last, 37);
    check("fr_done_cyc", done_cyc, 38);
    check("fr_done_cnt", done_cnt, 1);
    check("fr_busy_after", busy_after, 0);
    check("fr_count", outs.size(), 36);
    check("fr_last_cnt", lasts.size(), 1);
    check_data("fr");
    next_cycle();

    // Backpressure for 5 cycles mid-RUN.
    xs = '{300, -200, 150, -100, 50, 25};
    bp_start = 3;
    bp_len   = 5;
    run_frame(6, 200);
    check("bp_fir_en", fen_bp, 0);
    check("bp_in_ready", inr_bp, 0);
    check("bp_out_data_moved", od_chg, 0);
    check("bp_acc_cnt", acc_cnt, 6);
    check("bp_count", outs.size(), 38);
    check("bp_en_while_full", viol, 0);
    check("bp_fir_x_idle", fx_viol, 0);
    check_data("bp");
    clear_knobs();
    next_cycle();

    // Zero-length frame.
    xs.delete();
    run_frame(0, 50);
    check("zl_done_cyc", done_cyc, 1);
    check("zl_ov_cnt", ov_cnt, 0);
    check("zl_fen_cnt", fen_cnt, 0);
    check("zl_busy_after", busy_after, 0);
    next_cycle();

    // Reset after 3 accepted samples, then a clean frame.
    xs = '{11, 22, 33, 44, 55};
    rst_after = 3;
    run_frame(5, 100);
    check("mid_rst_outputs", int'(rst_snap), 0);
    check("mid_rst_acc_cnt", acc_cnt, 3);
    check("mid_rst_no_done", done_cnt, 0);
    next_cycle();
    Reset_n = 1'b1;
    next_cycle();
    clear_knobs();
    xs = '{-7, 13, 9};
    run_frame(3, 200);
    check("post_rst_count", outs.size(), 35);
    check("post_rst_done_cnt", done_cnt, 1);
    check_data("post_rst");
    next_cycle();

    // Start pulsed during RUN with a different length.
    xs = '{40, -30, 20};
    s2_cyc = 2;
    s2_len = 9;
    run_frame(3, 200);
    check("ign_count", outs.size(), 35);
    check("ign_last_cnt", lasts.size(), 1);
    if (lasts.size() > 0) check("ign_last_idx", lasts[0], 34);
    check("ign_acc_cnt", acc_cnt, 3);
    check("ign_done_cnt", done_cnt, 1);
    check_data("ign");
    clear_knobs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
